pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//   Pipeline sequencer for the 5-stage core. Merges stall requests from ID (load-use)
//   and MEM with an internal multi-cycle EX-op sequencer, and drives the per-stage
//   stall vector and exception flush. Sits beside the pc/if_id/id_ex/ex_mem/mem_wb
//   registers; every one of them consumes stall_o/flush_o.
// PARAMETERS
//   MC_CNT_W   6   width of multi-cycle length input / internal down-counter
//   STALL_W    6   stall vector width: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
// PORTS
//   clk             in   1          system clock, all state on rising edge
//   rst             in   1          synchronous, active-high reset (`RstEnable)
//   stallreq_id_i   in   1          ID requests stall (operand hazard)
//   stallreq_mem_i  in   1          MEM requests stall (memory not ready)
//   mc_start_i      in   1          EX holds a multi-cycle op (MADD/DIV), 1-cycle pulse
//   mc_cycles_i     in   MC_CNT_W   total EX stall cycles N for that op, sampled with mc_start_i
//   flush_i         in   1          exception taken this cycle
//   exc_pc_i        in   32         exception handler address (`InstAddrBus)
//   stall_o         out  STALL_W    per-stage hold; 1 = stage register keeps value
//   flush_o         out  1          clear all pipeline registers this cycle
//   new_pc_o        out  32         PC to load when flush_o=1, else `ZeroWord
//   mc_busy_o       out  1          multi-cycle op in progress (state BUSY)
//   mc_done_o       out  1          multi-cycle result valid for EX to consume
// BEHAVIOUR
// - Reset (rst=1 at clk edge): state=IDLE, cnt=0. While rst=1 all outputs forced 0.
// - States: IDLE, BUSY, DONE. cnt is a MC_CNT_W down-counter. N=0 is treated as N=1.
// - IDLE: mc_start_i & N<=1 -> DONE; mc_start_i & N>=2 -> BUSY, cnt<=N-1; else stay.
// - BUSY: cnt<=cnt-1; when cnt==1 -> DONE. mc_start_i ignored. mc_busy_o=1.
// - DONE: mc_done_o=1. If stallreq_mem_i=1 stay in DONE (EX frozen, result held);
//   else mc_start_i handled exactly as in IDLE (back-to-back ops), otherwise -> IDLE.
// - EX stall window: the mc_start_i cycle plus every BUSY cycle = exactly N cycles;
//   DONE cycle itself does not request EX stall.
// - stall_o (combinational from state + inputs), priority highest first:
//     flush_i                                  -> 6'b000000
//     stallreq_mem_i                           -> 6'b011111
//     mc_start_i accepted (IDLE/DONE) or BUSY  -> 6'b001111
//     stallreq_id_i                            -> 6'b000111
//     otherwise                                -> 6'b000000
// - Counter keeps decrementing in BUSY during MEM stall (unit runs independently).
// - flush_o = flush_i, new_pc_o = exc_pc_i when flush_i else 0, same cycle (0 latency).
//   flush_i in any state: next state IDLE, cnt<=0, mc_done_o never pulses for the
//   aborted op; a mc_start_i in the flush cycle is discarded.
// - Reset mid-op: identical to flush abort, no mc_done_o afterwards.
// - Width: cnt never wraps; N loaded as mc_cycles_i-1 only when mc_cycles_i>=2.
// STRUCTURE
// - Shared defines file gains: `StallNone/`StallId/`StallEx/`StallMem vectors,
//   `McIdle/`McBusy/`McDone state encodings, `StallBus (5:0).
// - One sub-module: mc_down_counter (load, dec, zero/one flags, MC_CNT_W wide).
// - Remainder: state register, next-state logic, output priority mux in pipe_ctrl.
// TESTING
// - rst=1 two cycles with all inputs toggling -> stall_o=0, flush_o=0, mc_* =0, state IDLE.
// - stallreq_id_i=1 alone -> stall_o=6'b000111; add stallreq_mem_i=1 -> 6'b011111.
// - mc_start_i, mc_cycles_i=4 at t -> stall_o=6'b001111 t..t+3, mc_busy_o t+1..t+3,
//   mc_done_o=1 at t+4 only, stall_o=0 at t+4; cycles=0 and 1 -> done at t+1.
// - DONE while stallreq_mem_i=1 for 3 cycles -> mc_done_o held 3 cycles, stall_o=6'b011111,
//   drops to IDLE the cycle after mem stall clears.
// - flush_i=1, exc_pc_i=32'h0000_0020 at BUSY cnt=2 -> flush_o=1, new_pc_o=32'h20,
//   stall_o=0 that cycle; state IDLE next; mc_done_o never asserted.
// - Back-to-back: mc_start_i(N=2) in DONE cycle -> stall_o=6'b001111, BUSY next, done 2 later.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stall vectors, sequencer states and widths for the pipeline controller
package pipe_ctrl_pkg;
    localparam int MC_CNT_W = 6;
    localparam int STALL_W  = 6;
    localparam int ADDR_W   = 32;
    // Stall vector bits: [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [ADDR_W-1:0]  ZERO_WORD  = '0;
    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;
    // Lengths 0 and 1 both finish after a single stall cycle
    function automatic logic mc_short(input logic [MC_CNT_W-1:0] n);
        return n <= MC_CNT_W'(1);
    endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/multi-cycle/exception signals between pipeline stages and pipe_ctrl
//   master: stage side, drives requests and consumes stall/flush
//   slave : pipe_ctrl side
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;
    logic                stallreq_id_i;
    logic                stallreq_mem_i;
    logic                mc_start_i;
    logic [MC_CNT_W-1:0] mc_cycles_i;
    logic                flush_i;
    logic [ADDR_W-1:0]   exc_pc_i;
    logic [STALL_W-1:0]  stall_o;
    logic                flush_o;
    logic [ADDR_W-1:0]   new_pc_o;
    logic                mc_busy_o;
    logic                mc_done_o;
    modport master (
        output stallreq_id_i, stallreq_mem_i, mc_start_i, mc_cycles_i, flush_i, exc_pc_i,
        input  stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
    );
    modport slave (
        input  stallreq_id_i, stallreq_mem_i, mc_start_i, mc_cycles_i, flush_i, exc_pc_i,
        output stall_o, flush_o, new_pc_o, mc_busy_o, mc_done_o
    );
endinterface

// File: rtl/pipe_ctrl_counter.sv
// mc_down_counter: loadable saturating down-counter with zero/one flags
//   clk, rst      : clock, synchronous active-high reset
//   clr_i         : clear to 0 (highest priority)
//   load_i        : load load_val_i
//   dec_i         : decrement, holds at 0 instead of wrapping
//   zero_o, one_o : count equals 0 / equals 1
module mc_down_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         one_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign zero_o = cnt_q == '0;
    assign one_o  = cnt_q == W'(1);
    always_comb begin
        cnt_d = clr_i ? '0 : load_i ? load_val_i : (dec_i && !zero_o) ? cnt_q - W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges ID/MEM stall requests with a multi-cycle EX sequencer, drives stall vector and flush
//   clk, rst : clock, synchronous active-high reset (all outputs forced 0 while asserted)
//   bus      : pipe_ctrl_if.slave carrying stall requests, multi-cycle start/length,
//              exception flush/pc in; stall vector, flush, new pc, busy/done out
module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input logic          clk,
    input logic          rst,
    pipe_ctrl_if.slave   bus
);
    mc_state_e           state_q, state_d;
    logic                start_ok, load, cnt_zero, cnt_one;
    logic [STALL_W-1:0]  stall;
    // A start in DONE is only taken once MEM releases the frozen EX result
    assign start_ok = bus.mc_start_i &&
                      (state_q == MC_IDLE || (state_q == MC_DONE && !bus.stallreq_mem_i));
    assign load     = start_ok && !mc_short(bus.mc_cycles_i);
    mc_down_counter #(.W(MC_CNT_W)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.flush_i),
        .load_i     (load),
        .load_val_i (bus.mc_cycles_i - MC_CNT_W'(1)),
        .dec_i      (state_q == MC_BUSY),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );
    always_comb begin
        state_d = MC_IDLE;
        if (bus.flush_i)              state_d = MC_IDLE;
        else if (start_ok)            state_d = mc_short(bus.mc_cycles_i) ? MC_DONE : MC_BUSY;
        else if (state_q == MC_BUSY)  state_d = (cnt_one || cnt_zero) ? MC_DONE : MC_BUSY;
        else if (state_q == MC_DONE)  state_d = bus.stallreq_mem_i ? MC_DONE : MC_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= MC_IDLE;
        else     state_q <= state_d;
    end
    always_comb begin
        stall = bus.flush_i                        ? STALL_NONE :
                bus.stallreq_mem_i                 ? STALL_MEM  :
                (start_ok || state_q == MC_BUSY)   ? STALL_EX   :
                bus.stallreq_id_i                  ? STALL_ID   : STALL_NONE;
    end
    assign bus.stall_o   = rst ? STALL_NONE : stall;
    assign bus.flush_o   = !rst && bus.flush_i;
    assign bus.new_pc_o  = (!rst && bus.flush_i) ? bus.exc_pc_i : ZERO_WORD;
    assign bus.mc_busy_o = !rst && state_q == MC_BUSY;
    assign bus.mc_done_o = !rst && state_q == MC_DONE;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven cycle trace plus a latency sequence for pipe_ctrl
module tb_pipe_ctrl;
    logic clk = 0;
    logic rst;
    int   n_chk = 0;
    int   n_fail = 0;
    pipe_ctrl_if bus ();
    pipe_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic        rst, id, mem, start;
        logic [5:0]  cyc;
        logic        flush;
        logic [31:0] pc;
        logic [5:0]  stall;
        logic        busy, done;
    } vec_t;
    vec_t vecs[$];
    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        rst                = v.rst;
        bus.stallreq_id_i  = v.id;
        bus.stallreq_mem_i = v.mem;
        bus.mc_start_i     = v.start;
        bus.mc_cycles_i    = v.cyc;
        bus.flush_i        = v.flush;
        bus.exc_pc_i       = v.pc;
    endtask
    initial begin
        vec_t idle;
        bit   seen;
        idle = '{0, 0, 0, 0, 6'd0, 0, 32'h0, 6'b000000, 0, 0};
        drive(idle);
        rst = 1;
        // rst id mem st cyc flush pc | stall busy done  (state at row start in trailing note)
        vecs.push_back('{1, 1, 1, 1, 6'd4, 1, 32'h20,       6'b000000, 0, 0}); // 0 reset
        vecs.push_back('{1, 0, 0, 1, 6'd2, 0, 32'h0,        6'b000000, 0, 0}); // 1 reset
        vecs.push_back('{0, 1, 0, 0, 6'd0, 0, 32'h0,        6'b000111, 0, 0}); // 2 IDLE
        vecs.push_back('{0, 1, 1, 0, 6'd0, 0, 32'h0,        6'b011111, 0, 0}); // 3 IDLE
        vecs.push_back('{0, 0, 1, 0, 6'd0, 0, 32'h0,        6'b011111, 0, 0}); // 4 IDLE
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 5 IDLE
        vecs.push_back('{0, 0, 0, 1, 6'd4, 0, 32'h0,        6'b001111, 0, 0}); // 6 IDLE start N=4
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 1, 0}); // 7 BUSY cnt3
        vecs.push_back('{0, 1, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 1, 0}); // 8 BUSY cnt2
        vecs.push_back('{0, 0, 0, 1, 6'd2, 0, 32'h0,        6'b001111, 1, 0}); // 9 BUSY cnt1, start ignored
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 1}); // 10 DONE
        vecs.push_back('{0, 0, 0, 1, 6'd0, 0, 32'h0,        6'b001111, 0, 0}); // 11 IDLE start N=0
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 1}); // 12 DONE
        vecs.push_back('{0, 0, 0, 1, 6'd1, 0, 32'h0,        6'b001111, 0, 0}); // 13 IDLE start N=1
        vecs.push_back('{0, 0, 1, 0, 6'd0, 0, 32'h0,        6'b011111, 0, 1}); // 14 DONE mem
        vecs.push_back('{0, 0, 1, 1, 6'd2, 0, 32'h0,        6'b011111, 0, 1}); // 15 DONE mem, start dropped
        vecs.push_back('{0, 0, 1, 0, 6'd0, 0, 32'h0,        6'b011111, 0, 1}); // 16 DONE mem
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 1}); // 17 DONE released
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 18 IDLE
        vecs.push_back('{0, 0, 0, 1, 6'd3, 0, 32'h0,        6'b001111, 0, 0}); // 19 IDLE start N=3
        vecs.push_back('{0, 0, 0, 0, 6'd0, 1, 32'h20,       6'b000000, 1, 0}); // 20 BUSY cnt2 flush
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 21 IDLE
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 22 IDLE
        vecs.push_back('{0, 0, 0, 1, 6'd1, 1, 32'h100,      6'b000000, 0, 0}); // 23 IDLE start+flush
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 24 IDLE
        vecs.push_back('{0, 0, 0, 1, 6'd2, 0, 32'h0,        6'b001111, 0, 0}); // 25 IDLE start N=2
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 1, 0}); // 26 BUSY cnt1
        vecs.push_back('{0, 0, 0, 1, 6'd2, 0, 32'h0,        6'b001111, 0, 1}); // 27 DONE back-to-back N=2
        vecs.push_back('{0, 0, 1, 0, 6'd0, 0, 32'h0,        6'b011111, 1, 0}); // 28 BUSY cnt1 under mem
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 1}); // 29 DONE
        vecs.push_back('{0, 0, 0, 1, 6'd5, 0, 32'h0,        6'b001111, 0, 0}); // 30 IDLE start N=5
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b001111, 1, 0}); // 31 BUSY cnt4
        vecs.push_back('{1, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 32 reset mid-op
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 33 IDLE
        vecs.push_back('{0, 0, 0, 0, 6'd0, 0, 32'h0,        6'b000000, 0, 0}); // 34 IDLE
        vecs.push_back('{0, 1, 1, 0, 6'd0, 1, 32'hdeadbeef, 6'b000000, 0, 0}); // 35 flush beats mem/id
        vecs.push_back('{0, 1, 0, 0, 6'd0, 0, 32'hdeadbeef, 6'b000111, 0, 0}); // 36 pc ignored without flush
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i]);
            @(negedge clk);
            chk("stall",  i, 32'(bus.stall_o),   32'(vecs[i].stall));
            chk("flush",  i, 32'(bus.flush_o),   32'(vecs[i].flush & ~vecs[i].rst));
            chk("new_pc", i, bus.new_pc_o,       (vecs[i].flush & ~vecs[i].rst) ? vecs[i].pc : 32'h0);
            chk("busy",   i, 32'(bus.mc_busy_o), 32'(vecs[i].busy));
            chk("done",   i, 32'(bus.mc_done_o), 32'(vecs[i].done));
        end
        // N=6 from IDLE: done must appear exactly 6 cycles after the start cycle, for one cycle
        @(posedge clk); #1;
        drive(idle);
        bus.mc_start_i  = 1;
        bus.mc_cycles_i = 6'd6;
        @(negedge clk);
        chk("n6_start_stall", 0, 32'(bus.stall_o), 32'h0f);
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(posedge clk); #1;
            drive(idle);
            @(negedge clk);
            if (bus.mc_done_o) begin
                seen = 1;
                chk("n6_latency", k, k, 6);
                chk("n6_done_stall", k, 32'(bus.stall_o), 32'h00);
            end else begin
                chk("n6_busy", k, 32'(bus.mc_busy_o), 32'h1);
            end
        end
        if (!seen) chk("n6_timeout", 20, 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("n6_done_drop", 0, 32'(bus.mc_done_o), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
